// File: rtl/mdr_mem_interface_pkg.sv
// Shared definitions for the MAR/MDR memory interface: bus width, handshake
// state encodings and a timer sizing helper.
package mdr_mem_interface_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  // Wide enough to hold timeout-1; never narrower than one bit.
  function automatic int unsigned timer_width(input int unsigned timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/mdr_mem_interface.sv
// MAR/MDR owner and req/ack memory handshake; MDR also feeds the datapath bus mux.
// Handshake runs IDLE -> REQ -> DONE -> IDLE with all outputs registered.
module mdr_mem_interface
  import mdr_mem_interface_pkg::*;
#(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] BusMuxInMDR,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned TMR_W = timer_width(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] mar_q,   mar_d;
  logic [DATA_W-1:0] mdr_q,   mdr_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              req_q,   req_d;
  logic              we_q,    we_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              err_q,   err_d;
  logic              finish;

  always_comb begin
    // NOTE: every _d signal is given a default first, so no path through the
    // case statement leaves one unassigned and infers a latch.
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    timer_d = timer_q;
    req_d   = req_q;
    we_d    = we_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    finish  = 1'b0;

    // MAR/MDR are writable from the bus whenever no request is outstanding.
    if (state_q != MEM_REQ) begin
      if (MARin) mar_d = BusMuxOut[ADDR_W-1:0];
      if (MDRin) mdr_d = BusMuxOut;
    end

    case (state_q)
      MEM_IDLE: begin
        if (Read || Write) begin
          state_d = MEM_REQ;
          we_d    = ~Read;       // read wins when both are asserted
          err_d   = 1'b0;
          timer_d = '0;
          req_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end

      MEM_REQ: begin
        if (mem_ack) begin
          if (!we_q) mdr_d = mem_rdata;
          finish = 1'b1;
        end else if (TIMEOUT_EN && (timer_q == TMR_LAST)) begin
          err_d  = 1'b1;
          finish = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      MEM_DONE: state_d = MEM_IDLE;

      default: state_d = MEM_IDLE;
    endcase

    if (finish) begin
      state_d = MEM_DONE;
      req_d   = 1'b0;
      we_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      timer_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= MEM_IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      timer_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      timer_q <= timer_d;
      req_q   <= req_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_addr    = mar_q;
  assign mem_wdata   = mdr_q;
  assign BusMuxInMDR = mdr_q;
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mdr_mem_interface.sv
// Directed bench for mdr_mem_interface: read, write, timeout, read/write
// priority, REQ-phase input masking and asynchronous clear.
module tb_mdr_mem_interface;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] BusMuxOut;
  logic        MARin, MDRin, Read, Write;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_req, mem_we;
  logic [31:0] BusMuxInMDR;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;

  mdr_mem_interface #(.ADDR_W(9), .TIMEOUT(16)) dut (
    .clock       (clock),
    .clear       (clear),
    .BusMuxOut   (BusMuxOut),
    .MARin       (MARin),
    .MDRin       (MDRin),
    .Read        (Read),
    .Write       (Write),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .BusMuxInMDR (BusMuxInMDR),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    clear = 1'b1; BusMuxOut = '0; MARin = 0; MDRin = 0; Read = 0; Write = 0;
    mem_rdata = '0; mem_ack = 0;

    // Reset state
    #3;
    check("rst_req",  mem_req, 0);
    check("rst_we",   mem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err",  err, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_mdr",  BusMuxInMDR, 0);
    tick(); tick();
    clear = 1'b0;
    tick();
    check("idle_req", mem_req, 0);

    // 1: MARin + Read, ack two cycles after req
    BusMuxOut = 32'h0000_0203; MARin = 1; Read = 1;
    tick();
    MARin = 0; Read = 0; BusMuxOut = '0;
    check("t1_req",  mem_req, 1);
    check("t1_we",   mem_we, 0);
    check("t1_busy", busy, 1);
    check("t1_addr", mem_addr, 9'h003);
    tick();
    check("t1_req_hold", mem_req, 1);
    check("t1_nodone",   done, 0);
    tick();
    mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 0; mem_rdata = '0;
    check("t1_done", done, 1);
    check("t1_req_drop", mem_req, 0);
    check("t1_busy_drop", busy, 0);
    check("t1_mdr", BusMuxInMDR, 32'hDEAD_BEEF);
    check("t1_err", err, 0);
    tick();
    check("t1_done_pulse", done, 0);

    // 2: MDRin, then MARin + Write, ack in first REQ cycle
    BusMuxOut = 32'h1234_5678; MDRin = 1;
    tick();
    MDRin = 0; BusMuxOut = 32'h0000_01F0; MARin = 1; Write = 1;
    tick();
    MARin = 0; Write = 0; BusMuxOut = '0;
    mem_ack = 1; mem_rdata = 32'hAAAA_5555;
    check("t2_req",   mem_req, 1);
    check("t2_we",    mem_we, 1);
    check("t2_wdata", mem_wdata, 32'h1234_5678);
    check("t2_addr",  mem_addr, 9'h1F0);
    tick();
    mem_ack = 0; mem_rdata = '0;
    check("t2_done", done, 1);
    check("t2_mdr_kept", BusMuxInMDR, 32'h1234_5678);
    check("t2_we_drop", mem_we, 0);
    tick();
    check("t2_done_pulse", done, 0);

    // 3: Read with no ack times out after 16 REQ cycles
    mem_rdata = 32'hBAD0_BAD0;
    Read = 1;
    tick();
    Read = 0;
    n = 0;
    for (int i = 0; i < 40 && mem_req; i++) begin
      n++;
      tick();
    end
    check("t3_req_cycles", n, 16);
    check("t3_err", err, 1);
    check("t3_done", done, 1);
    check("t3_mdr_kept", BusMuxInMDR, 32'h1234_5678);
    tick();
    check("t3_err_sticky", err, 1);
    check("t3_done_pulse", done, 0);

    // 3b: next Read clears err; ack on the last allowed cycle beats timeout
    Read = 1;
    tick();
    Read = 0;
    check("t3b_err_clr", err, 0);
    for (int i = 0; i < 15; i++) tick();
    check("t3b_req_last", mem_req, 1);
    mem_ack = 1; mem_rdata = 32'h0BAD_CAFE;
    tick();
    mem_ack = 0; mem_rdata = '0;
    check("t3b_done", done, 1);
    check("t3b_err", err, 0);
    check("t3b_mdr", BusMuxInMDR, 32'h0BAD_CAFE);
    tick();

    // 4: Read + Write together performs a read; REQ ignores loads/starts
    BusMuxOut = 32'h0000_0055; MARin = 1; Read = 1; Write = 1;
    tick();
    check("t4_we", mem_we, 0);
    check("t4_addr", mem_addr, 9'h055);
    BusMuxOut = 32'hFFFF_FFFF; MARin = 1; MDRin = 1; Read = 1; Write = 1;
    tick();
    MARin = 0; MDRin = 0; Read = 0; Write = 0; BusMuxOut = '0;
    check("t4_addr_kept", mem_addr, 9'h055);
    check("t4_mdr_kept", BusMuxInMDR, 32'h0BAD_CAFE);
    check("t4_req", mem_req, 1);
    mem_ack = 1; mem_rdata = 32'h1122_3344;
    tick();
    mem_ack = 0; mem_rdata = '0;
    check("t4_done", done, 1);
    check("t4_mdr", BusMuxInMDR, 32'h1122_3344);
    // DONE honours MARin but ignores Read
    BusMuxOut = 32'h0000_01AB; MARin = 1; Read = 1;
    tick();
    MARin = 0; Read = 0; BusMuxOut = '0;
    check("t4_no_second_req", mem_req, 0);
    check("t4_done_addr", mem_addr, 9'h1AB);
    tick();
    check("t4_still_idle", mem_req, 0);

    // 5: clear between edges during REQ
    Read = 1;
    tick();
    Read = 0;
    check("t5_req", mem_req, 1);
    #2 clear = 1'b1;
    #1;
    check("t5_req_async", mem_req, 0);
    check("t5_mdr_zero", BusMuxInMDR, 0);
    check("t5_addr_zero", mem_addr, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    clear = 1'b0;
    mem_ack = 1; mem_rdata = 32'h5555_5555;
    tick();
    check("t5_stray_done", done, 0);
    check("t5_stray_mdr", BusMuxInMDR, 0);
    tick();
    mem_ack = 0;
    check("t5_stray_done2", done, 0);
    check("t5_stray_req", mem_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
